uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter STABLE_TIME, default `UART_STABLE_COUNT, meaning idle-high cycles RXD must show after reset before a start bit is accepted.
REQ-002 SHALL have parameter BAUD_PERIOD_BITS, default $clog2(`UART_BAUD_PERIOD), meaning width of the baud period value.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 sync_reset  input  1  synchronous clear, active-high; same effect as reset_n.
REQ-006 baud_rate_period_m1  input  BAUD_PERIOD_BITS  clk cycles per bit minus 1; static during a frame.
REQ-007 RXD  input  1  asynchronous serial line; idle high.
REQ-008 SBUF_out  output  8  last correctly framed byte.
REQ-009 RI  output  1  one-cycle pulse: new byte in SBUF_out.
REQ-010 frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 rx_active  output  1  high whenever FSM is not IDLE.

Function
REQ-012 RXD SHALL pass through a 2-flop synchronizer (rxd_s); all decisions use rxd_s only.
REQ-013 stable_counter SHALL count consecutive cycles with rxd_s=1, saturating at STABLE_TIME, cleared to 0 when rxd_s=0; line_ready = (stable_counter == STABLE_TIME).
REQ-014 FSM SHALL be one-hot with states IDLE, START, DATA, STOP.
REQ-015 IDLE: on rxd_s=0 while line_ready=1 -> clear bit counter, go START; otherwise remain.
REQ-016 Bit counter SHALL be BAUD_PERIOD_BITS wide, cleared on each state entry and on each bit sample, incrementing otherwise.
REQ-017 START: when counter == (baud_rate_period_m1 >> 1), sample rxd_s; 0 -> go DATA, clear data index; 1 -> false start, go IDLE, no outputs.
REQ-018 DATA: when counter == baud_rate_period_m1, shift rxd_s into shift register LSB first (shift right, MSB in); increment 3-bit data index; after 8th sample go STOP.
REQ-019 STOP: when counter == baud_rate_period_m1, sample rxd_s; 1 -> load SBUF_out from shift register, pulse RI; 0 -> pulse frame_error, SBUF_out unchanged; in both cases go IDLE.
REQ-020 RI/frame_error SHALL be registered, asserting the cycle after the stop sample, exactly one cycle wide, never both high.
REQ-021 After a frame error with line held low (break), no new frame SHALL start until line_ready is regained.
REQ-022 Back-to-back frames: a start edge arriving the cycle after returning to IDLE SHALL be accepted.
REQ-023 SBUF_out SHALL hold its value until the next good frame; no overrun detection.

Reset
REQ-024 On reset_n=0 or sync_reset=1 at a clock edge: FSM -> IDLE, all counters 0, shift register 0, synchronizer flops 1, SBUF_out=0, RI=0, frame_error=0, rx_active=0.
REQ-025 Reset mid-frame SHALL abandon the frame silently; no RI or frame_error for it.

Structure
REQ-026 UART_STABLE_COUNT and UART_BAUD_PERIOD SHALL come from common.vh, shared with the transmitter; no local copies.
REQ-027 State indices SHALL be localparams inside uart_rx.
REQ-028 Synchronizer plus stable_counter SHALL be one sub-module, uart_rx_line_sync (outputs rxd_s, line_ready).

Verification
REQ-029 baud_rate_period_m1=9, line idle > STABLE_TIME, send 0xA5 (8N1, 10 clk/bit) -> single RI pulse, SBUF_out=0xA5, frame_error never high.
REQ-030 Low glitch of 3 clk on RXD in IDLE, period 9 -> returns to IDLE, no RI, no frame_error, SBUF_out unchanged.
REQ-031 Send 0x3C with stop bit driven 0 -> frame_error pulse once, no RI, SBUF_out keeps prior value.
REQ-032 Frames 0x00 then 0xFF with zero idle gap -> two RI pulses, SBUF_out 0x00 then 0xFF.
REQ-033 reset_n low for 1 clk in middle of DATA of 0x55 -> all outputs reset values, no RI; next frame 0x81 received correctly.
REQ-034 RXD held low through reset release, rises after 5 clk -> no reception before STABLE_TIME high cycles; subsequent 0x7E received.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
package uart_rx_pkg;

  // Payload width of one 8N1 frame.
  localparam int DATA_BITS = 8;

  // One-hot receiver states; bit positions match the index localparams in uart_rx.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } rx_state_t;

endpackage

// File: rtl/common.vh
// Settings shared by the UART transmitter and receiver.
`ifndef UART_COMMON_VH
`define UART_COMMON_VH

// Consecutive idle-high clock cycles required on the line before a start bit is trusted.
`define UART_STABLE_COUNT 8

// Nominal clk cycles per bit (100 MHz clock, 115200 baud).
`define UART_BAUD_PERIOD 868

`endif

// File: rtl/uart_rx_line_sync.sv
// RXD synchronizer plus idle-line qualifier for the UART receiver.
module uart_rx_line_sync #(
  parameter int STABLE_TIME = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_reset,
  input  logic rxd,
  output logic rxd_s,
  output logic line_ready
);

  localparam int CW = (STABLE_TIME < 1) ? 1 : $clog2(STABLE_TIME + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_TIME);

  logic          rxd_meta_reg;
  logic          rxd_s_reg;
  logic [CW-1:0] stable_counter_reg;

  // Two-flop synchronizer (reset to idle-high) and saturating count of consecutive high cycles.
  always_ff @(posedge clk) begin
    if (!reset_n || sync_reset) begin
      rxd_meta_reg       <= 1'b1;
      rxd_s_reg          <= 1'b1;
      stable_counter_reg <= '0;
    end else begin
      rxd_meta_reg <= rxd;
      rxd_s_reg    <= rxd_meta_reg;
      if (!rxd_s_reg) begin
        stable_counter_reg <= '0;
      end else if (stable_counter_reg != STABLE_MAX) begin
        stable_counter_reg <= stable_counter_reg + 1'b1;
      end
    end
  end

  assign rxd_s      = rxd_s_reg;
  assign line_ready = (stable_counter_reg == STABLE_MAX);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling driven by a runtime baud period.
`include "common.vh"

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int STABLE_TIME      = `UART_STABLE_COUNT,
  parameter int BAUD_PERIOD_BITS = $clog2(`UART_BAUD_PERIOD)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sync_reset,
  input  logic [BAUD_PERIOD_BITS-1:0] baud_rate_period_m1,
  input  logic                        RXD,
  output logic [7:0]                  SBUF_out,
  output logic                        RI,
  output logic                        frame_error,
  output logic                        rx_active
);

  // Bit positions of each state inside the one-hot state vector.
  localparam int S_IDLE  = 0;
  localparam int S_START = 1;
  localparam int S_DATA  = 2;
  localparam int S_STOP  = 3;

  logic rxd_s;
  logic line_ready;

  rx_state_t                   state_reg, state_next;
  logic [BAUD_PERIOD_BITS-1:0] bit_cnt_reg, bit_cnt_next;
  logic [2:0]                  data_idx_reg, data_idx_next;
  logic [DATA_BITS-1:0]        shift_data_reg, shift_data_next;
  logic [7:0]                  sbuf_reg, sbuf_next;
  logic                        ri_reg, ri_next;
  logic                        fe_reg, fe_next;
  logic [BAUD_PERIOD_BITS-1:0] half_period;

  uart_rx_line_sync #(
    .STABLE_TIME (STABLE_TIME)
  ) u_line_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_reset (sync_reset),
    .rxd        (RXD),
    .rxd_s      (rxd_s),
    .line_ready (line_ready)
  );

  // Start bit is checked half a period in, so the data samples land mid-bit.
  assign half_period = baud_rate_period_m1 >> 1;

  // State and datapath registers; reset drops any frame in progress without reporting it.
  always_ff @(posedge clk) begin
    if (!reset_n || sync_reset) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= '0;
      data_idx_reg   <= '0;
      shift_data_reg <= '0;
      sbuf_reg       <= '0;
      ri_reg         <= 1'b0;
      fe_reg         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      data_idx_reg   <= data_idx_next;
      shift_data_reg <= shift_data_next;
      sbuf_reg       <= sbuf_next;
      ri_reg         <= ri_next;
      fe_reg         <= fe_next;
    end
  end

  // Next-state and datapath decisions; the counter restarts on every state entry and bit sample.
  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg + 1'b1;
    data_idx_next   = data_idx_reg;
    shift_data_next = shift_data_reg;
    sbuf_next       = sbuf_reg;
    ri_next         = 1'b0;
    fe_next         = 1'b0;

    if (state_reg[S_IDLE]) begin
      bit_cnt_next = '0;
      if (!rxd_s && line_ready) begin
        state_next = ST_START;
      end
    end else if (state_reg[S_START]) begin
      if (bit_cnt_reg == half_period) begin
        bit_cnt_next = '0;
        if (!rxd_s) begin
          state_next    = ST_DATA;
          data_idx_next = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
    end else if (state_reg[S_DATA]) begin
      if (bit_cnt_reg == baud_rate_period_m1) begin
        bit_cnt_next    = '0;
        shift_data_next = {rxd_s, shift_data_reg[DATA_BITS-1:1]};
        data_idx_next   = data_idx_reg + 1'b1;
        if (data_idx_reg == 3'(DATA_BITS - 1)) begin
          state_next = ST_STOP;
        end
      end
    end else if (state_reg[S_STOP]) begin
      if (bit_cnt_reg == baud_rate_period_m1) begin
        bit_cnt_next = '0;
        state_next   = ST_IDLE;
        if (rxd_s) begin
          sbuf_next = shift_data_reg;
          ri_next   = 1'b1;
        end else begin
          fe_next = 1'b1;
        end
      end
    end else begin
      state_next   = ST_IDLE;
      bit_cnt_next = '0;
    end
  end

  assign SBUF_out    = sbuf_reg;
  assign RI          = ri_reg;
  assign frame_error = fe_reg;
  assign rx_active   = ~state_reg[S_IDLE];

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 10 clk per bit, short idle qualifier.
module tb_uart_rx;

  localparam int BPB = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           sync_reset;
  logic [BPB-1:0] baud_rate_period_m1;
  logic           RXD;
  logic [7:0]     SBUF_out;
  logic           RI;
  logic           frame_error;
  logic           rx_active;

  int n_total = 0;
  int n_bad   = 0;

  int         ri_count    = 0;
  int         fe_count    = 0;
  int         width_err   = 0;
  int         both_err    = 0;
  logic       active_seen = 1'b0;
  logic       prev_ri     = 1'b0;
  logic       prev_fe     = 1'b0;
  logic [7:0] sbuf_log [0:15];

  uart_rx #(
    .STABLE_TIME      (8),
    .BAUD_PERIOD_BITS (BPB)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .sync_reset          (sync_reset),
    .baud_rate_period_m1 (baud_rate_period_m1),
    .RXD                 (RXD),
    .SBUF_out            (SBUF_out),
    .RI                  (RI),
    .frame_error         (frame_error),
    .rx_active           (rx_active)
  );

  always #5 clk = ~clk;

  // Observe outputs on the falling edge: count pulses and log received bytes.
  always @(negedge clk) begin
    if (RI) begin
      if (ri_count < 16) sbuf_log[ri_count] = SBUF_out;
      ri_count++;
    end
    if (frame_error) fe_count++;
    if ((RI && prev_ri) || (frame_error && prev_fe)) width_err++;
    if (RI && frame_error) both_err++;
    if (rx_active) active_seen = 1'b1;
    prev_ri = RI;
    prev_fe = frame_error;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame, LSB first, 10 clk per bit; line left at the stop level.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    RXD = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      RXD = data[i];
      tick(10);
    end
    RXD = stop_bit;
    tick(10);
  endtask

  int ri0;
  int fe0;

  initial begin
    reset_n             = 1'b0;
    sync_reset          = 1'b0;
    baud_rate_period_m1 = 8'd9;
    RXD                 = 1'b1;
    tick(3);

    // Reset state
    chk("rst_sbuf", 32'(SBUF_out), 32'h00);
    chk("rst_ri", 32'(RI), 32'h0);
    chk("rst_fe", 32'(frame_error), 32'h0);
    chk("rst_active", 32'(rx_active), 32'h0);
    reset_n = 1'b1;
    tick(20);

    // Good frame 0xA5
    ri0 = ri_count; fe0 = fe_count;
    send_frame(8'hA5, 1'b1);
    tick(10);
    chk("a5_ri_pulses", 32'(ri_count - ri0), 32'd1);
    chk("a5_rx_byte", 32'(sbuf_log[ri0]), 32'hA5);
    chk("a5_sbuf", 32'(SBUF_out), 32'hA5);
    chk("a5_fe_pulses", 32'(fe_count - fe0), 32'd0);

    // 3-cycle low glitch in IDLE: false start
    ri0 = ri_count; fe0 = fe_count;
    RXD = 1'b0; tick(3);
    RXD = 1'b1; tick(20);
    chk("glitch_ri", 32'(ri_count - ri0), 32'd0);
    chk("glitch_fe", 32'(fe_count - fe0), 32'd0);
    chk("glitch_sbuf", 32'(SBUF_out), 32'hA5);
    chk("glitch_idle", 32'(rx_active), 32'h0);

    // 0x3C with low stop bit, then line held low (break)
    ri0 = ri_count; fe0 = fe_count;
    send_frame(8'h3C, 1'b0);
    tick(5);
    active_seen = 1'b0;
    tick(30);
    chk("fe_pulses", 32'(fe_count - fe0), 32'd1);
    chk("fe_no_ri", 32'(ri_count - ri0), 32'd0);
    chk("fe_sbuf_kept", 32'(SBUF_out), 32'hA5);
    chk("break_no_start", 32'(active_seen), 32'h0);
    RXD = 1'b1;
    tick(20);

    // 0x00 then 0xFF back to back
    ri0 = ri_count; fe0 = fe_count;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(10);
    chk("b2b_ri_pulses", 32'(ri_count - ri0), 32'd2);
    chk("b2b_first", 32'(sbuf_log[ri0]), 32'h00);
    chk("b2b_second", 32'(sbuf_log[ri0 + 1]), 32'hFF);
    chk("b2b_sbuf", 32'(SBUF_out), 32'hFF);

    // 0x55 interrupted by a one-cycle reset in the data phase
    ri0 = ri_count; fe0 = fe_count;
    RXD = 1'b0; tick(10);
    RXD = 1'b1; tick(10);
    RXD = 1'b0; tick(10);
    RXD = 1'b1; tick(5);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    chk("midrst_sbuf", 32'(SBUF_out), 32'h00);
    chk("midrst_active", 32'(rx_active), 32'h0);
    chk("midrst_ri", 32'(RI), 32'h0);
    chk("midrst_fe", 32'(frame_error), 32'h0);
    tick(40);
    chk("midrst_no_ri", 32'(ri_count - ri0), 32'd0);
    chk("midrst_no_fe", 32'(fe_count - fe0), 32'd0);
    ri0 = ri_count;
    send_frame(8'h81, 1'b1);
    tick(10);
    chk("x81_ri_pulses", 32'(ri_count - ri0), 32'd1);
    chk("x81_sbuf", 32'(SBUF_out), 32'h81);

    // Line low through reset release; start-like low before qualification is ignored
    RXD = 1'b0;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    active_seen = 1'b0;
    tick(5);
    RXD = 1'b1; tick(4);
    RXD = 1'b0; tick(20);
    chk("unqual_no_start", 32'(active_seen), 32'h0);
    chk("unqual_sbuf", 32'(SBUF_out), 32'h00);
    RXD = 1'b1; tick(20);
    ri0 = ri_count;
    send_frame(8'h7E, 1'b1);
    tick(10);
    chk("x7e_ri_pulses", 32'(ri_count - ri0), 32'd1);
    chk("x7e_sbuf", 32'(SBUF_out), 32'h7E);

    // Pulse shape over the whole run
    chk("pulse_width", 32'(width_err), 32'd0);
    chk("ri_fe_overlap", 32'(both_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
